// File: rtl/tqvp_uart_fifo.sv
// TinyQV peripheral: full-duplex 8N1 UART with programmable divisor and TX/RX FIFOs.
// Optional macro UART_PARITY_EN adds a parity bit (CTRL b4 enable, b5 odd) and STATUS b6.

module tqvp_uart_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_RESET  = 555,
    parameter int unsigned DIV_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    input  logic       data_read,
    output logic [7:0] data_out,
    output logic       rx_irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0]    DepthP  = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0]    PtrOne  = PW'(1);
    localparam logic [DIV_W-1:0] DivOne  = DIV_W'(1);
    localparam logic [DIV_W:0]   HalfOne = (DIV_W + 1)'(1);

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
`ifdef UART_PARITY_EN
        TxParity,
`endif
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
`ifdef UART_PARITY_EN
        RxParity,
`endif
        RxStop,
        RxWait
    } rx_state_e;

    // Bus decode
    logic wr_data, wr_ctrl, clr_sticky, flush, rx_pop;
    assign wr_data    = data_write && (address == 4'h0);
    assign wr_ctrl    = data_write && (address == 4'h4);
    assign clr_sticky = wr_ctrl && data_in[2];
    assign flush      = wr_ctrl && data_in[3];
    assign rx_pop     = data_read && (address == 4'h0);

    logic rx_in;
    assign rx_in = ui_in[7];

    logic unused_ui;
    assign unused_ui = ^ui_in[6:0];

    // Control registers
    logic [DIV_W-1:0] div_q, div_d;
    logic             tx_en_q, tx_en_d, rx_en_q, rx_en_d;
    logic [1:0]       ctrl_par;
`ifdef UART_PARITY_EN
    logic             par_en_q, par_en_d, par_odd_q, par_odd_d;
    assign ctrl_par = {par_odd_q, par_en_q};
`else
    assign ctrl_par = 2'b00;
`endif

    always_comb begin
        div_d   = div_q;
        tx_en_d = tx_en_q;
        rx_en_d = rx_en_q;
`ifdef UART_PARITY_EN
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
`endif
        if (data_write && (address == 4'h2)) div_d[7:0] = data_in;
        if (data_write && (address == 4'h3)) div_d[DIV_W-1:8] = data_in[DIV_W-9:0];
        if (wr_ctrl) begin
            tx_en_d = data_in[0];
            rx_en_d = data_in[1];
`ifdef UART_PARITY_EN
            par_en_d  = data_in[4];
            par_odd_d = data_in[5];
`endif
        end
    end

    // TX FIFO
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d, tx_count;
    logic          tx_empty, tx_full, tx_pop, tx_pop_ok, tx_push_ok;
    logic [7:0]    tx_head;

    assign tx_count   = tx_wptr_q - tx_rptr_q;
    assign tx_empty   = (tx_count == '0);
    assign tx_full    = (tx_count == DepthP);
    assign tx_head    = tx_mem[tx_rptr_q[AW-1:0]];
    assign tx_pop_ok  = tx_pop && !tx_empty;
    assign tx_push_ok = wr_data && (!tx_full || tx_pop_ok) && !flush;

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        if (flush) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
        end else begin
            if (tx_pop_ok)  tx_rptr_d = tx_rptr_q + PtrOne;
            if (tx_push_ok) tx_wptr_d = tx_wptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wptr_q[AW-1:0]] <= data_in;
    end

    // RX FIFO
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d, rx_count;
    logic          rx_empty, rx_full, rx_push, rx_pop_ok, rx_push_ok, overrun_set;
    logic [7:0]    rx_head;

    assign rx_count    = rx_wptr_q - rx_rptr_q;
    assign rx_empty    = (rx_count == '0);
    assign rx_full     = (rx_count == DepthP);
    assign rx_head     = rx_mem[rx_rptr_q[AW-1:0]];
    assign rx_pop_ok   = rx_pop && !rx_empty;
    assign rx_push_ok  = rx_push && (!rx_full || rx_pop_ok) && !flush;
    assign overrun_set = rx_push && rx_full && !rx_pop_ok && !flush;

    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        if (flush) begin
            rx_wptr_d = '0;
            rx_rptr_d = '0;
        end else begin
            if (rx_pop_ok)  rx_rptr_d = rx_rptr_q + PtrOne;
            if (rx_push_ok) rx_wptr_d = rx_wptr_q + PtrOne;
        end
    end

    // TX FSM; each bit counter reloads from div_q only at a bit boundary
    tx_state_e        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic             tx_line, tx_bit_end, tx_start_ok;
`ifdef UART_PARITY_EN
    logic             tx_par_q, tx_par_d;
`endif

    assign tx_bit_end  = (tx_cnt_q == '0);
    assign tx_start_ok = tx_en_q && !tx_empty && !flush;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_bit_end ? div_q : tx_cnt_q - DivOne;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = div_q;
                if (tx_start_ok) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = TxStart;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^tx_head) ^ par_odd_q;
`endif
                end
            end
            TxStart: begin
                tx_line = 1'b0;
                if (tx_bit_end) begin
                    tx_state_d = TxData;
                    tx_bit_d   = 3'd0;
                end
            end
            TxData: begin
                tx_line = tx_shift_q[0];
                if (tx_bit_end) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = par_en_q ? TxParity : TxStop;
`else
                        tx_state_d = TxStop;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            TxParity: begin
                tx_line = tx_par_q;
                if (tx_bit_end) tx_state_d = TxStop;
            end
`endif
            TxStop: begin
                if (tx_bit_end) begin
                    if (tx_start_ok) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_state_d = TxStart;
`ifdef UART_PARITY_EN
                        tx_par_d   = (^tx_head) ^ par_odd_q;
`endif
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // RX FSM; START waits half a bit so later samples land mid-bit
    rx_state_e        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_half_m1;
    logic [DIV_W:0]   rx_half;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic             rx_prev_q, rx_bit_end, frame_set, parity_set, rx_bad;
`ifdef UART_PARITY_EN
    logic             rx_bad_q, rx_bad_d;
    assign rx_bad = rx_bad_q;
`else
    assign rx_bad = 1'b0;
`endif

    assign rx_bit_end = (rx_cnt_q == '0);
    assign rx_half    = ({1'b0, div_q} + HalfOne) >> 1;
    assign rx_half_m1 = (rx_half == '0) ? '0 : DIV_W'(rx_half - HalfOne);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_bit_end ? div_q : rx_cnt_q - DivOne;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
`ifdef UART_PARITY_EN
        rx_bad_d   = rx_bad_q;
`endif
        case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = rx_half_m1;
`ifdef UART_PARITY_EN
                rx_bad_d = 1'b0;
`endif
                if (rx_prev_q && !rx_in) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_bit_end) begin
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_in ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_bit_end) begin
                    rx_shift_d = {rx_in, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = par_en_q ? RxParity : RxStop;
`else
                        rx_state_d = RxStop;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            RxParity: begin
                if (rx_bit_end) begin
                    if (rx_in != ((^rx_shift_q) ^ par_odd_q)) begin
                        parity_set = 1'b1;
                        rx_bad_d   = 1'b1;
                    end
                    rx_state_d = RxStop;
                end
            end
`endif
            RxStop: begin
                if (rx_bit_end) begin
                    if (rx_in) begin
                        rx_push    = !rx_bad;
                        rx_state_d = RxIdle;
                    end else begin
                        frame_set  = 1'b1;
                        rx_state_d = RxWait;
                    end
                end
            end
            RxWait: begin
                if (rx_in) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
        if (!rx_en_q) rx_state_d = RxIdle;
    end

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wptr_q[AW-1:0]] <= rx_shift_q;
    end

    // Sticky flags and interrupt
    logic overrun_q, overrun_d, frame_q, frame_d, parity_q, parity_d, rx_irq_q, rx_irq_d;

    always_comb begin
        overrun_d = (overrun_q && !clr_sticky) || overrun_set;
        frame_d   = (frame_q && !clr_sticky) || frame_set;
`ifdef UART_PARITY_EN
        parity_d  = (parity_q && !clr_sticky) || parity_set;
`else
        parity_d  = 1'b0;
`endif
        rx_irq_d  = !rx_empty || overrun_q || frame_q || parity_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= DIV_W'(DIV_RESET);
            tx_en_q    <= 1'b1;
            rx_en_q    <= 1'b1;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_prev_q  <= 1'b1;
            overrun_q  <= 1'b0;
            frame_q    <= 1'b0;
            parity_q   <= 1'b0;
            rx_irq_q   <= 1'b0;
`ifdef UART_PARITY_EN
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            tx_par_q   <= 1'b0;
            rx_bad_q   <= 1'b0;
`endif
        end else begin
            div_q      <= div_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_prev_q  <= rx_in;
            overrun_q  <= overrun_d;
            frame_q    <= frame_d;
            parity_q   <= parity_d;
            rx_irq_q   <= rx_irq_d;
`ifdef UART_PARITY_EN
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            tx_par_q   <= tx_par_d;
            rx_bad_q   <= rx_bad_d;
`endif
        end
    end

    // Outputs
    logic [7:0] status;
    assign status = {frame_q, parity_q, tx_state_q != TxIdle, overrun_q,
                     tx_empty, tx_full, rx_full, !rx_empty};
    assign uo_out = {7'b0000000, tx_line};
    assign rx_irq = rx_irq_q;

    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0:    data_out = rx_empty ? 8'h00 : rx_head;
            4'h1:    data_out = status;
            4'h2:    data_out = div_q[7:0];
            4'h3:    data_out = 8'(div_q[DIV_W-1:8]);
            4'h4:    data_out = {2'b00, ctrl_par, 2'b00, rx_en_q, tx_en_q};
            4'h5:    data_out = 8'(rx_count);
            4'h6:    data_out = 8'(tx_count);
            default: data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_uart_fifo.sv
// Directed self-checking bench for tqvp_uart_fifo (default build, FIFO_DEPTH=8).
`timescale 1ns/1ps

module tb_tqvp_uart_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic       data_read;
    logic [7:0] data_out;
    logic       rx_irq;

    int vectors = 0;
    int miscompares = 0;

    tqvp_uart_fifo #(
        .FIFO_DEPTH(8),
        .DIV_RESET (555),
        .DIV_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ui_in     (ui_in),
        .uo_out    (uo_out),
        .address   (address),
        .data_write(data_write),
        .data_in   (data_in),
        .data_read (data_read),
        .data_out  (data_out),
        .rx_irq    (rx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Called just after a negedge; the write lands on the following posedge.
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    // One 8N1 frame at 4 clocks per bit, followed by 2 idle clocks.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        ui_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ui_in[7] = b[i];
            repeat (4) @(negedge clk);
        end
        ui_in[7] = stop;
        repeat (4) @(negedge clk);
        ui_in[7] = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        ui_in      = 8'h80;
        address    = 4'h0;
        data_write = 1'b0;
        data_in    = 8'h00;
        data_read  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        address = 4'h1; #1;
        vectors++;
        if (data_out !== 8'h08) begin
            $display("FAIL reset_status: got %h want %h", data_out, 8'h08); miscompares++;
        end
        address = 4'h2; #1;
        vectors++;
        if (data_out !== 8'h2B) begin
            $display("FAIL reset_div_lo: got %h want %h", data_out, 8'h2B); miscompares++;
        end
        address = 4'h3; #1;
        vectors++;
        if (data_out !== 8'h02) begin
            $display("FAIL reset_div_hi: got %h want %h", data_out, 8'h02); miscompares++;
        end
        address = 4'h4; #1;
        vectors++;
        if (data_out !== 8'h03) begin
            $display("FAIL reset_ctrl: got %h want %h", data_out, 8'h03); miscompares++;
        end
        vectors++;
        if (uo_out !== 8'h01) begin
            $display("FAIL reset_uo_out: got %h want %h", uo_out, 8'h01); miscompares++;
        end
        vectors++;
        if (rx_irq !== 1'b0) begin
            $display("FAIL reset_rx_irq: got %b want %b", rx_irq, 1'b0); miscompares++;
        end
        address = 4'h0; #1;
        vectors++;
        if (data_out !== 8'h00) begin
            $display("FAIL reset_data_empty: got %h want %h", data_out, 8'h00); miscompares++;
        end
        @(negedge clk);
        bus_write(4'h7, 8'hFF);
        address = 4'h7; #1;
        vectors++;
        if (data_out !== 8'h00) begin
            $display("FAIL unmapped_read: got %h want %h", data_out, 8'h00); miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_tx_back_to_back;
        logic [19:0] exp_tx;
        logic        found;
        exp_tx = 20'b1101000110_1010101010;
        bus_write(4'h2, 8'h03);
        bus_write(4'h3, 8'h00);
        bus_write(4'h0, 8'h55);
        bus_write(4'h0, 8'hA3);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (uo_out[0] === 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        vectors++;
        if (!found) begin
            $display("FAIL tx_start_seen: got line idle want start bit"); miscompares++;
            return;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            vectors++;
            if (uo_out[0] !== exp_tx[k]) begin
                $display("FAIL tx_bit[%0d]: got %b want %b", k, uo_out[0], exp_tx[k]);
                miscompares++;
            end
            if (k != 19) repeat (4) @(negedge clk);
        end
        @(negedge clk);
        address = 4'h1; #1;
        vectors++;
        if (data_out[5] !== 1'b1) begin
            $display("FAIL tx_busy_in_stop: got %b want %b", data_out[5], 1'b1); miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (data_out[5] !== 1'b0) begin
            $display("FAIL tx_busy_drop: got %b want %b", data_out[5], 1'b0); miscompares++;
        end
        vectors++;
        if (uo_out[0] !== 1'b1) begin
            $display("FAIL tx_idle_line: got %b want %b", uo_out[0], 1'b1); miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_rx_single;
        send_rx(8'h3C, 1'b1);
        @(negedge clk);
        address = 4'h5; #1;
        vectors++;
        if (data_out !== 8'h01) begin
            $display("FAIL rx_count_one: got %h want %h", data_out, 8'h01); miscompares++;
        end
        vectors++;
        if (rx_irq !== 1'b1) begin
            $display("FAIL rx_irq_set: got %b want %b", rx_irq, 1'b1); miscompares++;
        end
        address   = 4'h0;
        data_read = 1'b1; #1;
        vectors++;
        if (data_out !== 8'h3C) begin
            $display("FAIL rx_data: got %h want %h", data_out, 8'h3C); miscompares++;
        end
        @(negedge clk);
        data_read = 1'b0;
        address   = 4'h5; #1;
        vectors++;
        if (data_out !== 8'h00) begin
            $display("FAIL rx_count_after_pop: got %h want %h", data_out, 8'h00); miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (rx_irq !== 1'b0) begin
            $display("FAIL rx_irq_clear: got %b want %b", rx_irq, 1'b0); miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_rx_overrun;
        for (int i = 0; i < 9; i++) send_rx(8'(8'h10 + i), 1'b1);
        address = 4'h5; #1;
        vectors++;
        if (data_out !== 8'h08) begin
            $display("FAIL overrun_count: got %h want %h", data_out, 8'h08); miscompares++;
        end
        address = 4'h1; #1;
        vectors++;
        if (data_out !== 8'h1B) begin
            $display("FAIL overrun_status: got %h want %h", data_out, 8'h1B); miscompares++;
        end
        address   = 4'h0;
        data_read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++;
            if (data_out !== 8'(8'h10 + i)) begin
                $display("FAIL overrun_fifo[%0d]: got %h want %h", i, data_out, 8'(8'h10 + i));
                miscompares++;
            end
            @(negedge clk);
        end
        data_read = 1'b0;
        address   = 4'h1; #1;
        vectors++;
        if (data_out !== 8'h18) begin
            $display("FAIL overrun_sticky: got %h want %h", data_out, 8'h18); miscompares++;
        end
        vectors++;
        if (rx_irq !== 1'b1) begin
            $display("FAIL overrun_irq: got %b want %b", rx_irq, 1'b1); miscompares++;
        end
        bus_write(4'h4, 8'h04);
        address = 4'h1; #1;
        vectors++;
        if (data_out !== 8'h08) begin
            $display("FAIL overrun_cleared: got %h want %h", data_out, 8'h08); miscompares++;
        end
        address = 4'h4; #1;
        vectors++;
        if (data_out !== 8'h00) begin
            $display("FAIL ctrl_after_clear: got %h want %h", data_out, 8'h00); miscompares++;
        end
        @(negedge clk); #1;
        vectors++;
        if (rx_irq !== 1'b0) begin
            $display("FAIL irq_after_clear: got %b want %b", rx_irq, 1'b0); miscompares++;
        end
        bus_write(4'h4, 8'h03);
    endtask

    task automatic test_rx_errors;
        ui_in[7] = 1'b0;
        @(negedge clk);
        ui_in[7] = 1'b1;
        repeat (10) @(negedge clk);
        address = 4'h5; #1;
        vectors++;
        if (data_out !== 8'h00) begin
            $display("FAIL false_start_count: got %h want %h", data_out, 8'h00); miscompares++;
        end
        address = 4'h1; #1;
        vectors++;
        if (data_out !== 8'h08) begin
            $display("FAIL false_start_status: got %h want %h", data_out, 8'h08); miscompares++;
        end
        send_rx(8'h81, 1'b0);
        @(negedge clk);
        address = 4'h1; #1;
        vectors++;
        if (data_out !== 8'h88) begin
            $display("FAIL frame_err_status: got %h want %h", data_out, 8'h88); miscompares++;
        end
        address = 4'h5; #1;
        vectors++;
        if (data_out !== 8'h00) begin
            $display("FAIL frame_err_count: got %h want %h", data_out, 8'h00); miscompares++;
        end
        vectors++;
        if (rx_irq !== 1'b1) begin
            $display("FAIL frame_err_irq: got %b want %b", rx_irq, 1'b1); miscompares++;
        end
        bus_write(4'h4, 8'h07);
        address = 4'h1; #1;
        vectors++;
        if (data_out !== 8'h08) begin
            $display("FAIL frame_err_cleared: got %h want %h", data_out, 8'h08); miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_tx_flush;
        bus_write(4'h4, 8'h02);
        for (int i = 0; i < 9; i++) bus_write(4'h0, 8'(8'h20 + i));
        address = 4'h6; #1;
        vectors++;
        if (data_out !== 8'h08) begin
            $display("FAIL tx_count_full: got %h want %h", data_out, 8'h08); miscompares++;
        end
        address = 4'h1; #1;
        vectors++;
        if (data_out !== 8'h04) begin
            $display("FAIL tx_full_status: got %h want %h", data_out, 8'h04); miscompares++;
        end
        vectors++;
        if (uo_out[0] !== 1'b1) begin
            $display("FAIL tx_disabled_line: got %b want %b", uo_out[0], 1'b1); miscompares++;
        end
        bus_write(4'h4, 8'h09);
        address = 4'h6; #1;
        vectors++;
        if (data_out !== 8'h00) begin
            $display("FAIL flush_tx_count: got %h want %h", data_out, 8'h00); miscompares++;
        end
        address = 4'h5; #1;
        vectors++;
        if (data_out !== 8'h00) begin
            $display("FAIL flush_rx_count: got %h want %h", data_out, 8'h00); miscompares++;
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (uo_out[0] !== 1'b1) begin
            $display("FAIL flush_line_idle: got %b want %b", uo_out[0], 1'b1); miscompares++;
        end
        address = 4'h4; #1;
        vectors++;
        if (data_out !== 8'h01) begin
            $display("FAIL flush_ctrl: got %h want %h", data_out, 8'h01); miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        bus_write(4'h4, 8'h03);
        bus_write(4'h0, 8'h5A);
        repeat (3) @(negedge clk);
        vectors++;
        if (uo_out[0] !== 1'b0) begin
            $display("FAIL pre_reset_start_bit: got %b want %b", uo_out[0], 1'b0); miscompares++;
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (uo_out[0] !== 1'b1) begin
            $display("FAIL async_reset_line: got %b want %b", uo_out[0], 1'b1); miscompares++;
        end
        address = 4'h1; #1;
        vectors++;
        if (data_out !== 8'h08) begin
            $display("FAIL async_reset_status: got %h want %h", data_out, 8'h08); miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_tx_back_to_back;
        test_rx_single;
        test_rx_overrun;
        test_rx_errors;
        test_tx_flush;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
